// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering a load/store request port with configurable wait states.
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   i_mem_req          request valid, accepted while o_mem_ready=1
//   i_mem_wr_en        1 = store, 0 = load
//   i_mem_addr         byte address (word-aligned, within memory depth)
//   i_mem_wr_data      store data
//   o_mem_ready        idle and able to accept
//   o_mem_rd_data      registered load result, held until the next successful load
//   o_mem_rd_valid     one-cycle load response pulse
//   o_mem_wr_done      one-cycle store commit pulse
//   o_mem_err          one-cycle rejection pulse (misaligned or out of range)
module dmem_responder #(
    parameter int DATA_WIDTH_P     = 32,
    parameter int MEM_ADDR_WIDTH_P = 8,
    parameter int WAIT_CYCLES_P    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_mem_req,
    input  logic                    i_mem_wr_en,
    input  logic [DATA_WIDTH_P-1:0] i_mem_addr,
    input  logic [DATA_WIDTH_P-1:0] i_mem_wr_data,
    output logic                    o_mem_ready,
    output logic [DATA_WIDTH_P-1:0] o_mem_rd_data,
    output logic                    o_mem_rd_valid,
    output logic                    o_mem_wr_done,
    output logic                    o_mem_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES_P == 0) ? 4'd0 : 4'(WAIT_CYCLES_P - 1);
    state_t                      r_state, w_next;
    logic [3:0]                  r_cnt;
    logic                        r_wr_en;
    logic [DATA_WIDTH_P-1:0]     r_addr, r_wr_data, r_rd_data;
    logic [DATA_WIDTH_P-1:0]     r_mem [0:2**MEM_ADDR_WIDTH_P-1];
    logic                        w_wr_en, w_err, w_enter_resp;
    logic [DATA_WIDTH_P-1:0]     w_addr, w_wr_data;
    logic [MEM_ADDR_WIDTH_P-1:0] w_idx;
    // In IDLE the access is taken straight from the inputs so a zero-wait build can commit on the accept edge.
    always_comb begin
        w_wr_en      = (r_state == S_IDLE) ? i_mem_wr_en   : r_wr_en;
        w_addr       = (r_state == S_IDLE) ? i_mem_addr    : r_addr;
        w_wr_data    = (r_state == S_IDLE) ? i_mem_wr_data : r_wr_data;
        w_err        = (w_addr[1:0] != 2'b00) || (|w_addr[DATA_WIDTH_P-1:MEM_ADDR_WIDTH_P+2]);
        w_idx        = w_addr[MEM_ADDR_WIDTH_P+1:2];
        w_next       = r_state;
        case (r_state)
            S_IDLE:  if (i_mem_req) w_next = (WAIT_CYCLES_P == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP) && !reset;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_mem_req) begin
                r_wr_en   <= i_mem_wr_en;
                r_addr    <= i_mem_addr;
                r_wr_data <= i_mem_wr_data;
                r_cnt     <= CNT_INIT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp && !w_err && !w_wr_en) r_rd_data <= r_mem[w_idx];
        end
    end
    // Memory array has no reset: contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (w_enter_resp && !w_err && w_wr_en) r_mem[w_idx] <= w_wr_data;
    end
    assign o_mem_ready    = (r_state == S_IDLE) && !reset;
    assign o_mem_rd_data  = r_rd_data;
    assign o_mem_rd_valid = (r_state == S_RESP) && !w_err && !w_wr_en;
    assign o_mem_wr_done  = (r_state == S_RESP) && !w_err && w_wr_en;
    assign o_mem_err      = (r_state == S_RESP) && w_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with two and zero wait states.
module tb_dmem_responder;
    localparam logic [2:0] RD = 3'b100, WR = 3'b010, ER = 3'b001, NONE = 3'b000;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  kind;
        logic [31:0] exp;
    } vec_t;
    logic        clk = 1'b0, reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wd = '0, b_addr = '0, b_wd = '0;
    logic        a_ready, a_rv, a_wdn, a_err, b_ready, b_rv, b_wdn, b_err;
    logic [31:0] a_rd, b_rd;
    int          checks = 0, errors = 0;
    vec_t        tbl [13];
    always #5 clk = ~clk;
    dmem_responder #(.DATA_WIDTH_P(32), .MEM_ADDR_WIDTH_P(8), .WAIT_CYCLES_P(2)) dut_a (
        .clk(clk), .reset(reset), .i_mem_req(a_req), .i_mem_wr_en(a_we), .i_mem_addr(a_addr),
        .i_mem_wr_data(a_wd), .o_mem_ready(a_ready), .o_mem_rd_data(a_rd), .o_mem_rd_valid(a_rv),
        .o_mem_wr_done(a_wdn), .o_mem_err(a_err));
    dmem_responder #(.DATA_WIDTH_P(32), .MEM_ADDR_WIDTH_P(8), .WAIT_CYCLES_P(0)) dut_b (
        .clk(clk), .reset(reset), .i_mem_req(b_req), .i_mem_wr_en(b_we), .i_mem_addr(b_addr),
        .i_mem_wr_data(b_wd), .o_mem_ready(b_ready), .o_mem_rd_data(b_rd), .o_mem_rd_valid(b_rv),
        .o_mem_wr_done(b_wdn), .o_mem_err(b_err));
    function automatic logic [2:0] pulses(input bit sel);
        return sel ? {b_rv, b_wdn, b_err} : {a_rv, a_wdn, a_err};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask
    // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
    task automatic acc(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] kind, input logic [31:0] exp, input string nm);
        int lat;
        if (sel) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wd = data; end
        else begin a_req = 1'b1; a_we = we; a_addr = addr; a_wd = data; end
        chk({nm, " ready_before"}, {31'b0, sel ? b_ready : a_ready}, 32'd1);
        @(posedge clk);
        #1;
        a_req = 1'b0; b_req = 1'b0;
        a_addr = 32'hFFFF_FFFF; a_wd = 32'hBAD0_BAD0; b_addr = 32'hFFFF_FFFF; b_wd = 32'hBAD0_BAD0;
        @(negedge clk);
        lat = 0;
        while (pulses(sel) == NONE && lat < 20) begin
            cyc();
            lat++;
        end
        chk({nm, " latency"}, lat, sel ? 32'd0 : 32'd2);
        chk({nm, " pulses"}, {29'b0, pulses(sel)}, {29'b0, kind});
        chk({nm, " rd_data"}, sel ? b_rd : a_rd, exp);
        cyc();
        chk({nm, " idle_after"}, {28'b0, sel ? b_ready : a_ready, pulses(sel)}, 32'h8);
    endtask
    initial begin
        int prev, nacc, nresp;
        logic [31:0] cur;
        tbl[0]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, WR, 32'h0000_0000};
        tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, WR, 32'h0000_0000};
        tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         RD, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 32'h0000_0012, 32'h0,         ER, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b0, 32'h0000_0400, 32'h0,         ER, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0,         RD, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, WR, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         RD, 32'hA5A5_A5A5};
        tbl[8]  = '{1'b1, 32'h0000_0013, 32'h1111_1111, ER, 32'hA5A5_A5A5};
        tbl[9]  = '{1'b0, 32'h0000_0010, 32'h0,         RD, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 32'h8000_0010, 32'h2222_2222, ER, 32'hDEAD_BEEF};
        tbl[11] = '{1'b0, 32'h0000_0010, 32'h0,         RD, 32'hDEAD_BEEF};
        tbl[12] = '{1'b0, 32'h0000_0020, 32'h0,         RD, 32'h0000_0000};
        a_req = 1'b1;
        @(negedge clk);
        repeat (3) cyc();
        chk("ready_in_reset", {31'b0, a_ready}, 32'd0);
        reset = 1'b0;
        a_req = 1'b0;
        cyc();
        chk("reset_a", {a_ready, a_rd[30:0]}, 32'h8000_0000);
        chk("reset_a_pulses", {29'b0, pulses(1'b0)}, 32'd0);
        chk("reset_b", {b_ready, b_rd[30:0], pulses(1'b1)}, 32'h8000_0000 << 3);
        for (int i = 0; i < 13; i++)
            acc(1'b0, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].kind, tbl[i].exp, $sformatf("vec%0d", i));
        // Request held high with the address flipping after every accept.
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        prev = -1; nacc = 0; nresp = 0; cur = 32'h0;
        for (int c = 0; c < 20; c++) begin
            logic rdy;
            rdy = a_ready;
            if (a_rv) begin
                nresp++;
                chk($sformatf("hold_data%0d", nresp), a_rd, (cur == 32'h10) ? 32'hDEAD_BEEF : 32'h0);
            end
            @(posedge clk);
            if (rdy) begin
                if (prev >= 0) chk($sformatf("hold_spacing%0d", nacc), c - prev, 32'd4);
                prev = c; nacc++; cur = a_addr;
            end
            @(negedge clk);
            if (rdy) a_addr = (a_addr == 32'h10) ? 32'h20 : 32'h10;
        end
        a_req = 1'b0;
        chk("hold_accepts", nacc, 32'd5);
        chk("hold_responses", nresp, 32'd5);
        repeat (4) cyc();
        // Store aborted by reset while waiting.
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wd = 32'h1234_5678;
        cyc();
        a_req = 1'b0; reset = 1'b1;
        chk("abort_busy", {31'b0, a_ready}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk($sformatf("abort_rst_pulses%0d", c), {29'b0, pulses(1'b0)}, 32'd0);
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk($sformatf("abort_post_pulses%0d", c), {28'b0, a_ready, pulses(1'b0)}, 32'h8);
        end
        acc(1'b0, 1'b0, 32'h10, 32'h0, RD, 32'hDEAD_BEEF, "abort_ld10");
        acc(1'b0, 1'b0, 32'h20, 32'h0, RD, 32'h0000_0000, "abort_ld20");
        // Zero-wait build: back-to-back stores then loads.
        for (int i = 0; i < 16; i++)
            acc(1'b1, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 257), WR, 32'h0, $sformatf("b_st%0d", i));
        for (int i = 0; i < 16; i++)
            acc(1'b1, 1'b0, 32'(i * 4), 32'h0, RD, 32'hC0DE_0000 + 32'(i * 257), $sformatf("b_ld%0d", i));
        acc(1'b1, 1'b0, 32'h0000_0006, 32'h0, ER, 32'hC0DE_0000 + 32'(15 * 257), "b_misaligned");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
